branch_resolve_seq: RTL and testbench

Control-side sequencer for conditional branches (BEQ, BNE, BLE, BGT) in the multicycle processor. It accepts a decoded branch request from the main control unit and drives the ALU compare enable plus UC_control/UC_op to the branch-condition gate. It samples the gate's single-bit taken result and issues a one-cycle PC write to the branch target when the branch is taken. It is the consuming end of the gate's update signal; the main control unit waits for branch_done before continuing.

---
 rtl/branch_resolve_seq.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_seq.sv
// branch_resolve_seq: control-side sequencer for conditional branches.
// Drives the ALU compare and the branch-condition gate, samples the taken
// result, and issues a one-cycle PC write to the branch target when taken.
// Optional build macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters on ports taken_cnt / not_taken_cnt.
module branch_resolve_seq #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_req,
  input  logic [1:0]       branch_op,
  input  logic             update_UC,
  output logic             alu_cmp,
  output logic             UC_control,
  output logic [1:0]       UC_op,
  output logic             pc_write,
  output logic             pc_src,
  output logic             taken,
  output logic             busy,
  output logic             branch_done
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
`endif
);

  localparam int unsigned LAT_W = 4;
  localparam int unsigned OP_W  = 2;

  // Reject configurations the latency counter cannot represent.
  if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_alu_lat
    $error("branch_resolve_seq: ALU_LAT must be in 1..15");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("branch_resolve_seq: CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_EVAL  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              taken_d;
  logic              alu_cmp_d, uc_control_d, pc_write_d, pc_src_d;
  logic              busy_d, branch_done_d;
  logic [OP_W-1:0]   uc_op_d;

  // Next-state logic; outputs are decoded from the next state so they
  // come straight out of flops and track the registered state exactly.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    taken_d = taken;

    unique case (state_q)
      S_IDLE: begin
        if (branch_req) begin
          op_d    = branch_op;
          cnt_d   = '0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        cnt_d = cnt_q + LAT_W'(1);
        if (cnt_q == LAT_W'(ALU_LAT - 1)) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d = update_UC;
        state_d = update_UC ? S_WRITE : S_DONE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    alu_cmp_d     = (state_d == S_CMP) || (state_d == S_EVAL);
    uc_control_d  = (state_d == S_EVAL);
    uc_op_d       = alu_cmp_d ? op_d : '0;
    pc_write_d    = (state_d == S_WRITE);
    pc_src_d      = (state_d == S_WRITE);
    busy_d        = (state_d != S_IDLE);
    branch_done_d = (state_d == S_DONE);
  end

  // State, latched op, latency counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      taken       <= 1'b0;
      alu_cmp     <= 1'b0;
      UC_control  <= 1'b0;
      UC_op       <= '0;
      pc_write    <= 1'b0;
      pc_src      <= 1'b0;
      busy        <= 1'b0;
      branch_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      taken       <= taken_d;
      alu_cmp     <= alu_cmp_d;
      UC_control  <= uc_control_d;
      UC_op       <= uc_op_d;
      pc_write    <= pc_write_d;
      pc_src      <= pc_src_d;
      busy        <= busy_d;
      branch_done <= branch_done_d;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating outcome counters, bumped as each branch leaves EVAL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (state_q == S_EVAL) begin
      if (update_UC) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end else begin
        if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_seq.sv
// Directed bench for branch_resolve_seq: one instance with ALU_LAT=1 and
// one with ALU_LAT=3. Output vectors are packed as
// {alu_cmp, UC_control, UC_op[1:0], pc_write, pc_src, taken, busy, branch_done}.
module tb_branch_resolve_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic req1, upd1, req3, upd3;
  logic [1:0] op1, op3;

  logic a1, c1, w1, s1, t1, b1, d1;
  logic a3, c3, w3, s3, t3, b3, d3;
  logic [1:0] uo1, uo3;
`ifdef BRANCH_STATS_EN
  logic [1:0] tc1, ntc1, tc3, ntc3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_seq #(.ALU_LAT(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(rst_n), .branch_req(req1), .branch_op(op1),
    .update_UC(upd1), .alu_cmp(a1), .UC_control(c1), .UC_op(uo1),
    .pc_write(w1), .pc_src(s1), .taken(t1), .busy(b1), .branch_done(d1)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc1), .not_taken_cnt(ntc1)
`endif
  );

  branch_resolve_seq #(.ALU_LAT(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(rst_n), .branch_req(req3), .branch_op(op3),
    .update_UC(upd3), .alu_cmp(a3), .UC_control(c3), .UC_op(uo3),
    .pc_write(w3), .pc_src(s3), .taken(t3), .busy(b3), .branch_done(d3)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(tc3), .not_taken_cnt(ntc3)
`endif
  );

  logic [8:0] v1, v3;
  assign v1 = {a1, c1, uo1, w1, s1, t1, b1, d1};
  assign v3 = {a3, c3, uo3, w3, s3, t3, b3, d3};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef BRANCH_STATS_EN
  task automatic run1(input logic [1:0] op, input logic upd);
    op1 = op; upd1 = upd; req1 = 1'b1;
    step();
    req1 = 1'b0;
    repeat (5) step();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req1 = 1'b0; op1 = 2'b00; upd1 = 1'b0;
    req3 = 1'b0; op3 = 2'b00; upd3 = 1'b0;
    repeat (2) step();
    chk("reset_u1", 16'(v1), 16'h000);
    chk("reset_u3", 16'(v3), 16'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // BEQ taken, ALU_LAT=1
    op1 = 2'b00; upd1 = 1'b1; req1 = 1'b1;
    step(); req1 = 1'b0;
    chk("beq_c1_cmp",   16'(v1), 16'(9'b1_0_00_0_0_0_1_0));
    step();
    chk("beq_c2_eval",  16'(v1), 16'(9'b1_1_00_0_0_0_1_0));
    step();
    chk("beq_c3_write", 16'(v1), 16'(9'b0_0_00_1_1_1_1_0));
    step();
    chk("beq_c4_done",  16'(v1), 16'(9'b0_0_00_0_0_1_1_1));
    step();
    chk("beq_c5_idle",  16'(v1), 16'(9'b0_0_00_0_0_1_0_0));

    // Reset asserted during CMP aborts the branch and clears taken
    op1 = 2'b00; upd1 = 1'b1; req1 = 1'b1;
    step(); req1 = 1'b0;
    chk("abort_c1_cmp", 16'(v1), 16'(9'b1_0_00_0_0_1_1_0));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async_clear", 16'(v1), 16'h000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_resume", 16'(v1), 16'h000);
    end

    // BNE not taken; a request held during DONE is ignored
    op1 = 2'b01; upd1 = 1'b0; req1 = 1'b1;
    step(); req1 = 1'b0;
    chk("bne_c1_cmp",  16'(v1), 16'(9'b1_0_01_0_0_0_1_0));
    upd1 = 1'b1;  // ignored outside EVAL
    step();
    chk("bne_c2_eval", 16'(v1), 16'(9'b1_1_01_0_0_0_1_0));
    upd1 = 1'b0;
    step();
    chk("bne_c3_done", 16'(v1), 16'(9'b0_0_00_0_0_0_1_1));
    req1 = 1'b1; op1 = 2'b11;
    step(); req1 = 1'b0;
    chk("bne_c4_idle_req_in_done_ignored", 16'(v1), 16'(9'b0_0_00_0_0_0_0_0));
    step();
    chk("bne_c5_idle", 16'(v1), 16'(9'b0_0_00_0_0_0_0_0));

    // Request while busy is ignored; BGT taken keeps its op
    op1 = 2'b11; upd1 = 1'b1; req1 = 1'b1;
    step();
    chk("busy_c1_cmp", 16'(v1), 16'(9'b1_0_11_0_0_0_1_0));
    op1 = 2'b10;  // req1 still high while busy
    step(); req1 = 1'b0;
    chk("busy_c2_eval_op_kept", 16'(v1), 16'(9'b1_1_11_0_0_0_1_0));
    step();
    chk("busy_c3_write", 16'(v1), 16'(9'b0_0_00_1_1_1_1_0));
    step();
    chk("busy_c4_done",  16'(v1), 16'(9'b0_0_00_0_0_1_1_1));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("busy_single_done", 16'(v1), 16'(9'b0_0_00_0_0_1_0_0));
    end

    // Latency scaling: ALU_LAT=3, BGT taken
    op3 = 2'b11; upd3 = 1'b1; req3 = 1'b1;
    step(); req3 = 1'b0;
    op3 = 2'b00;  // post-acceptance change has no effect
    for (int i = 1; i <= 3; i++) begin
      chk("lat3_cmp", 16'(v3), 16'(9'b1_0_11_0_0_0_1_0));
      step();
    end
    chk("lat3_c4_eval",  16'(v3), 16'(9'b1_1_11_0_0_0_1_0));
    step();
    chk("lat3_c5_write", 16'(v3), 16'(9'b0_0_00_1_1_1_1_0));
    step();
    chk("lat3_c6_done",  16'(v3), 16'(9'b0_0_00_0_0_1_1_1));
    step();
    chk("lat3_c7_idle",  16'(v3), 16'(9'b0_0_00_0_0_1_0_0));

`ifdef BRANCH_STATS_EN
    // Saturating statistics with CNT_W=2
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("stats_reset_tc",  16'(tc1),  16'd0);
    chk("stats_reset_ntc", 16'(ntc1), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) run1(2'b00, 1'b1);
    for (int i = 0; i < 2; i++) run1(2'b01, 1'b0);
    chk("stats_taken_sat", 16'(tc1),  16'd3);
    chk("stats_not_taken", 16'(ntc1), 16'd2);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("stats_clear_tc",  16'(tc1),  16'd0);
    chk("stats_clear_ntc", 16'(ntc1), 16'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
